// File: rtl/uart_pkg.sv
// Shared types and limits for the UART receive/transmit blocks.
package uart_pkg;

   localparam int unsigned MIN_CLKS_PER_BIT = 8;
   localparam int unsigned MIN_DATA_BITS    = 5;
   localparam int unsigned MAX_DATA_BITS    = 9;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } uart_rx_state_e;

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period strobe generator: first strobe half a bit after restart, then one per bit period.
module uart_bit_timer #(
   parameter int unsigned CLKS_PER_BIT = 434
) (
   input  logic clk,
   input  logic rst_n,
   input  logic restart,
   output logic sample_stb
);

   localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
   localparam int unsigned HALF  = CLKS_PER_BIT / 2;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);
   // Preload so the count reaches LAST exactly HALF cycles after restart.
   localparam logic [CNT_W-1:0] LOAD = CNT_W'(CLKS_PER_BIT - HALF);

   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clk or negedge rst_n) begin : p_cnt
      if (!rst_n) begin
         cnt        <= '0;
         sample_stb <= 1'b0;
      end else if (restart) begin
         cnt        <= LOAD;
         sample_stb <= 1'b0;
      end else if (cnt == LAST) begin
         cnt        <= '0;
         sample_stb <= 1'b1;
      end else begin
         cnt        <= cnt + CNT_W'(1);
         sample_stb <= 1'b0;
      end
   end

endmodule

// File: rtl/uart_rx_frame.sv
// UART frame receiver with synchroniser, false-start rejection, error flags and valid/ready output.
// Optional parity stage enabled by defining UART_RX_PARITY_EN.
module uart_rx_frame
   import uart_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = 434,
   parameter int unsigned DATA_BITS    = 8,
   parameter int unsigned STOP_BITS    = 1,
   parameter int unsigned PARITY_ODD   = 0
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 serial_rx,
   output logic [DATA_BITS-1:0] data_out,
   output logic                 data_valid,
   input  logic                 data_ready,
   output logic                 frame_err,
   output logic                 parity_err,
   output logic                 overrun,
   output logic                 busy
);

   localparam int unsigned BCNT_W = 4;

   // Parameter range checks at elaboration.
   if (CLKS_PER_BIT < MIN_CLKS_PER_BIT) begin : g_bad_cpb
      $error("uart_rx_frame: CLKS_PER_BIT must be >= %0d", MIN_CLKS_PER_BIT);
   end
   if (DATA_BITS < MIN_DATA_BITS || DATA_BITS > MAX_DATA_BITS) begin : g_bad_db
      $error("uart_rx_frame: DATA_BITS must be %0d..%0d", MIN_DATA_BITS, MAX_DATA_BITS);
   end
   if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_sb
      $error("uart_rx_frame: STOP_BITS must be 1 or 2");
   end
   if (PARITY_ODD > 1) begin : g_bad_po
      $error("uart_rx_frame: PARITY_ODD must be 0 or 1");
   end

   uart_rx_state_e       state, state_next;
   logic                 rx_meta, rx_s;
   logic                 stb;
   logic [DATA_BITS-1:0] shreg;
   logic [BCNT_W-1:0]    bit_cnt;
   logic                 ferr_acc;

   logic restart_c, shift_c, bcnt_clr_c, bcnt_inc_c, stop_c, done_c, load_c;
   logic frame_err_c;

   // Two-flop synchroniser, idle-high reset.
   always_ff @(posedge clk or negedge rst_n) begin : p_sync
      if (!rst_n) begin
         rx_meta <= 1'b1;
         rx_s    <= 1'b1;
      end else begin
         rx_meta <= serial_rx;
         rx_s    <= rx_meta;
      end
   end

   uart_bit_timer #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_timer (
      .clk       (clk),
      .rst_n     (rst_n),
      .restart   (restart_c),
      .sample_stb(stb)
   );

   always_ff @(posedge clk or negedge rst_n) begin : p_state
      if (!rst_n) state <= IDLE;
      else        state <= state_next;
   end

   always_comb begin : p_next
      state_next = state;
      restart_c  = 1'b0;
      shift_c    = 1'b0;
      bcnt_clr_c = 1'b0;
      bcnt_inc_c = 1'b0;
      stop_c     = 1'b0;
      done_c     = 1'b0;
      case (state)
         IDLE: begin
            if (!rx_s) begin
               state_next = START;
               restart_c  = 1'b1;
               bcnt_clr_c = 1'b1;
            end
         end
         START: begin
            // A line back high at mid-start is a glitch, not a frame.
            if (stb) state_next = rx_s ? IDLE : DATA;
         end
         DATA: begin
            if (stb) begin
               shift_c = 1'b1;
               if (bit_cnt == BCNT_W'(DATA_BITS - 1)) begin
                  bcnt_clr_c = 1'b1;
`ifdef UART_RX_PARITY_EN
                  state_next = PARITY;
`else
                  state_next = STOP;
`endif
               end else begin
                  bcnt_inc_c = 1'b1;
               end
            end
         end
`ifdef UART_RX_PARITY_EN
         PARITY: begin
            if (stb) state_next = STOP;
         end
`endif
         STOP: begin
            if (stb) begin
               stop_c = 1'b1;
               if (bit_cnt == BCNT_W'(STOP_BITS - 1)) begin
                  done_c     = 1'b1;
                  state_next = IDLE;
               end else begin
                  bcnt_inc_c = 1'b1;
               end
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin : p_datapath
      if (!rst_n) begin
         shreg    <= '0;
         bit_cnt  <= '0;
         ferr_acc <= 1'b0;
      end else begin
         if (shift_c) shreg <= {rx_s, shreg[DATA_BITS-1:1]};
         if (bcnt_clr_c)      bit_cnt <= '0;
         else if (bcnt_inc_c) bit_cnt <= bit_cnt + BCNT_W'(1);
         if (restart_c)              ferr_acc <= 1'b0;
         else if (stop_c && !rx_s)   ferr_acc <= 1'b1;
      end
   end

   // Includes the final stop sample, which is being taken this cycle.
   assign frame_err_c = ferr_acc | ~rx_s;
   assign load_c      = done_c && (!data_valid || data_ready);

   always_ff @(posedge clk or negedge rst_n) begin : p_out
      if (!rst_n) begin
         data_out   <= '0;
         data_valid <= 1'b0;
         frame_err  <= 1'b0;
         overrun    <= 1'b0;
         busy       <= 1'b0;
      end else begin
         overrun <= done_c && data_valid && !data_ready;
         busy    <= (state_next != IDLE);
         if (load_c) begin
            data_out   <= shreg;
            frame_err  <= frame_err_c;
            data_valid <= 1'b1;
         end else if (data_ready) begin
            data_valid <= 1'b0;
         end
      end
   end

`ifdef UART_RX_PARITY_EN
   logic par_bit;

   always_ff @(posedge clk or negedge rst_n) begin : p_parity
      if (!rst_n) begin
         par_bit    <= 1'b0;
         parity_err <= 1'b0;
      end else begin
         if (state == PARITY && stb) par_bit <= rx_s;
         if (load_c) parity_err <= par_bit ^ (^shreg) ^ 1'(PARITY_ODD);
      end
   end
`else
   assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_frame.sv
// Self-checking bench for uart_rx_frame: frame-level reference model plus directed scenarios.
module tb_uart_rx_frame;

   localparam int CPB  = 16;
   localparam int H    = CPB / 2;
   localparam int PODD = 0;
`ifdef UART_RX_PARITY_EN
   localparam int P   = 1;
   localparam int LAT = 171;
`else
   localparam int P   = 0;
   localparam int LAT = 155;
`endif

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic rx_line [2];
   logic rdy [2];

   logic [7:0] d0;
   logic [6:0] d1;
   logic v0, v1, fe0, fe1, pe0, pe1, ov0, ov1, b0, b1;

   always #5 clk = ~clk;

   uart_rx_frame #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .STOP_BITS(1), .PARITY_ODD(PODD)) u_dut (
      .clk(clk), .rst_n(rst_n), .serial_rx(rx_line[0]), .data_out(d0), .data_valid(v0),
      .data_ready(rdy[0]), .frame_err(fe0), .parity_err(pe0), .overrun(ov0), .busy(b0));

   uart_rx_frame #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .STOP_BITS(2), .PARITY_ODD(PODD)) u_dut7 (
      .clk(clk), .rst_n(rst_n), .serial_rx(rx_line[1]), .data_out(d1), .data_valid(v1),
      .data_ready(rdy[1]), .frame_err(fe1), .parity_err(pe1), .overrun(ov1), .busy(b1));

   logic [8:0] a_data [2];
   logic a_valid [2], a_fe [2], a_pe [2], a_ovr [2];
   assign a_data[0] = {1'b0, d0};
   assign a_data[1] = {2'b00, d1};
   assign a_valid[0] = v0;  assign a_valid[1] = v1;
   assign a_fe[0]    = fe0; assign a_fe[1]    = fe1;
   assign a_pe[0]    = pe0; assign a_pe[1]    = pe1;
   assign a_ovr[0]   = ov0; assign a_ovr[1]   = ov1;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc   = 0;

   function automatic int db(input int i);
      return (i == 0) ? 8 : 7;
   endfunction
   function automatic int sb(input int i);
      return (i == 0) ? 1 : 2;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, act, exp, cyc);
      end
   endtask

   // Reference model: each sent frame completes at a known edge; the output register
   // then follows the valid/ready and overrun rules.
   typedef struct {
      int         idx;
      int         t;
      logic [8:0] data;
      logic       fe;
      logic       pe;
   } frame_t;

   frame_t     pend [$];
   logic       m_valid [2], m_fe [2], m_pe [2], m_ovr [2];
   logic [8:0] m_data [2];

   always @(posedge clk) begin
      cyc = cyc + 1;
      if (!rst_n) begin
         pend.delete();
         for (int i = 0; i < 2; i++) begin
            m_valid[i] = 1'b0; m_fe[i] = 1'b0; m_pe[i] = 1'b0;
            m_ovr[i] = 1'b0;   m_data[i] = '0;
         end
      end else begin
         for (int i = 0; i < 2; i++) begin
            bit     hit;
            frame_t f;
            hit = 1'b0;
            m_ovr[i] = 1'b0;
            for (int k = pend.size() - 1; k >= 0; k--) begin
               if (pend[k].idx == i && pend[k].t == cyc) begin
                  f = pend[k];
                  hit = 1'b1;
                  pend.delete(k);
               end
            end
            if (hit) begin
               if (!m_valid[i] || rdy[i]) begin
                  m_valid[i] = 1'b1; m_data[i] = f.data; m_fe[i] = f.fe; m_pe[i] = f.pe;
               end else begin
                  m_ovr[i] = 1'b1;
               end
            end else if (m_valid[i] && rdy[i]) begin
               m_valid[i] = 1'b0;
            end
         end
      end
   end

   // Per-cycle compare against the model, plus event monitors for directed checks.
   int         rise_cnt [2], hi_cnt [2], ovr_cnt [2], rise_cyc [2];
   logic [8:0] rise_data [2];
   logic       rise_fe [2], rise_pe [2], prev_v [2];

   always @(posedge clk) begin
      #1;
      if (rst_n) begin
         for (int i = 0; i < 2; i++) begin
            chk($sformatf("valid%0d", i), 32'(a_valid[i]), 32'(m_valid[i]));
            chk($sformatf("data%0d", i), 32'(a_data[i]), 32'(m_data[i]));
            chk($sformatf("ferr%0d", i), 32'(a_fe[i]), 32'(m_fe[i]));
            chk($sformatf("perr%0d", i), 32'(a_pe[i]), 32'(m_pe[i]));
            chk($sformatf("ovr%0d", i), 32'(a_ovr[i]), 32'(m_ovr[i]));
            if (a_valid[i] && !prev_v[i]) begin
               rise_cnt[i]++;
               rise_cyc[i]  = cyc;
               rise_data[i] = a_data[i];
               rise_fe[i]   = a_fe[i];
               rise_pe[i]   = a_pe[i];
            end
            if (a_valid[i]) hi_cnt[i]++;
            if (a_ovr[i])   ovr_cnt[i]++;
            prev_v[i] = a_valid[i];
         end
      end else begin
         prev_v[0] = 1'b0;
         prev_v[1] = 1'b0;
      end
   end

   task automatic clear_mon();
      for (int i = 0; i < 2; i++) begin
         rise_cnt[i] = 0; hi_cnt[i] = 0; ovr_cnt[i] = 0;
      end
   endtask

   // Drives one frame on line i; abort_bit >= 0 pulses reset at that bit index instead.
   task automatic send_frame(input int i, input logic [8:0] data, input logic stop_ok,
                             input logic par_good, input int abort_bit, output int e0);
      logic [15:0] fr;
      logic        par_exp;
      frame_t      f;
      int          n;
      n = 0;
      fr = '0;
      par_exp = (^data) ^ 1'(PODD);
      fr[n] = 1'b0; n++;
      for (int b = 0; b < db(i); b++) begin fr[n] = data[b]; n++; end
      if (P == 1) begin fr[n] = par_good ? par_exp : ~par_exp; n++; end
      for (int s = 0; s < sb(i); s++) begin fr[n] = stop_ok; n++; end
      @(negedge clk);
      e0 = cyc + 1;
      f.idx = i; f.t = e0 + 3 + H + (db(i) + P + sb(i)) * CPB;
      f.data = data; f.fe = ~stop_ok; f.pe = (P == 1) && !par_good;
      pend.push_back(f);
      for (int k = 0; k < n; k++) begin
         if (k == abort_bit) begin
            rx_line[i] = 1'b1;
            rst_n = 1'b0;
            #1;
            chk("abort_busy", 32'(b1), 32'd0);
            chk("abort_valid", 32'(v1), 32'd0);
            chk("abort_data", 32'(d1), 32'd0);
            repeat (3) @(negedge clk);
            rst_n = 1'b1;
            repeat (2 * CPB) @(negedge clk);
            return;
         end
         rx_line[i] = fr[k];
         repeat (CPB) @(negedge clk);
      end
      rx_line[i] = 1'b1;
      repeat (2 * CPB) @(negedge clk);
   endtask

   initial begin
      int e0;
      rx_line[0] = 1'b1; rx_line[1] = 1'b1;
      rdy[0] = 1'b1;     rdy[1] = 1'b1;
      clear_mon();
      repeat (3) @(negedge clk);
      chk("rst_valid", 32'(v0), 32'd0);
      chk("rst_data", 32'(d0), 32'd0);
      chk("rst_flags", 32'({fe0, pe0, ov0, b0}), 32'd0);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);

      // 1: clean frame, latency and single-cycle valid.
      clear_mon();
      send_frame(0, 9'h0A5, 1'b1, 1'b1, -1, e0);
      chk("t1_rises", 32'(rise_cnt[0]), 32'd1);
      chk("t1_latency", 32'(rise_cyc[0] - e0), 32'(LAT));
      chk("t1_data", 32'(rise_data[0]), 32'h0A5);
      chk("t1_flags", 32'({rise_fe[0], rise_pe[0]}), 32'd0);
      chk("t1_hi_cycles", 32'(hi_cnt[0]), 32'd1);

      // 2: 4-cycle low glitch is rejected at the first mid-bit strobe.
      clear_mon();
      @(negedge clk);
      rx_line[0] = 1'b0;
      e0 = cyc + 1;
      for (int k = 1; k <= H + 6; k++) begin
         @(posedge clk);
         #1;
         if (cyc == e0 + 3)     rx_line[0] = 1'b1;
         if (cyc == e0 + 1)     chk("t2_busy_pre", 32'(b0), 32'd0);
         if (cyc == e0 + 2)     chk("t2_busy_up", 32'(b0), 32'd1);
         if (cyc == e0 + 2 + H) chk("t2_busy_hold", 32'(b0), 32'd1);
         if (cyc == e0 + 3 + H) chk("t2_busy_down", 32'(b0), 32'd0);
      end
      repeat (2 * CPB) @(negedge clk);
      chk("t2_no_output", 32'(rise_cnt[0]), 32'd0);

      // 3: bad stop bit still delivered with frame_err; next good frame clears it.
      clear_mon();
      send_frame(0, 9'h03C, 1'b0, 1'b1, -1, e0);
      chk("t3_data", 32'(rise_data[0]), 32'h03C);
      chk("t3_ferr", 32'(rise_fe[0]), 32'd1);
      send_frame(0, 9'h055, 1'b1, 1'b1, -1, e0);
      chk("t3_data2", 32'(rise_data[0]), 32'h055);
      chk("t3_ferr2", 32'(rise_fe[0]), 32'd0);

      // 4: consumer stalled -> second frame dropped with one overrun pulse.
      @(negedge clk);
      rdy[0] = 1'b0;
      clear_mon();
      send_frame(0, 9'h011, 1'b1, 1'b1, -1, e0);
      send_frame(0, 9'h022, 1'b1, 1'b1, -1, e0);
      chk("t4_valid_held", 32'(v0), 32'd1);
      chk("t4_data_held", 32'(d0), 32'h011);
      chk("t4_ovr_pulses", 32'(ovr_cnt[0]), 32'd1);
      rdy[0] = 1'b1;
      repeat (2) @(negedge clk);
      chk("t4_consumed", 32'(v0), 32'd0);
      repeat (4 * CPB) @(negedge clk);
      chk("t4_nothing_more", 32'(rise_cnt[0]), 32'd1);

`ifdef UART_RX_PARITY_EN
      // 5: even parity, good then bad.
      clear_mon();
      send_frame(0, 9'h007, 1'b1, 1'b1, -1, e0);
      chk("t5_perr_good", 32'(rise_pe[0]), 32'd0);
      send_frame(0, 9'h007, 1'b1, 1'b0, -1, e0);
      chk("t5_perr_bad", 32'(rise_pe[0]), 32'd1);
      chk("t5_data", 32'(rise_data[0]), 32'h007);
`endif

      // 6: 7-bit/2-stop instance, reset mid-DATA then resend.
      clear_mon();
      send_frame(1, 9'h041, 1'b1, 1'b1, 4, e0);
      chk("t6_aborted", 32'(rise_cnt[1]), 32'd0);
      send_frame(1, 9'h041, 1'b1, 1'b1, -1, e0);
      chk("t6_rises", 32'(rise_cnt[1]), 32'd1);
      chk("t6_data", 32'(rise_data[1]), 32'h041);
      chk("t6_latency", 32'(rise_cyc[1] - e0), 32'(LAT));
      chk("t6_ferr", 32'(rise_fe[1]), 32'd0);

      repeat (4) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
